// File: rtl/div_arbiter.sv
// div_arbiter
//   Shares one iterative divider between two requesters. The requester ports
//   are arbitrated round-robin. Ops whose result is fixed by the operands
//   bypass the divider:
//     - divide by zero
//     - signed 0x80000000 / -1
//   All other ops are issued to the divider. At most one op is in flight at
//   any time.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   reqN_valid/op/vregid/a/b         requester N op
//                                      op[0]=unsigned, op[1]=remainder
//   reqN_ready                       requester N op accepted this cycle
//   flush                            discard all in-flight work
//   div_idle, div_out_en,            divider handshake and results
//     div_q, div_rem
//   div_in_en, div_a, div_b,         divider start pulse and operands
//     div_signed
//   writeback_en/vregid/val          result pulse, tag and value
//   busy                             an op is being issued or awaited
module div_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [2:0]  req0_op,
    input  logic [4:0]  req0_vregid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [2:0]  req1_op,
    input  logic [4:0]  req1_vregid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    input  logic        flush,
    input  logic        div_idle,
    input  logic        div_out_en,
    input  logic [31:0] div_q,
    input  logic [31:0] div_rem,
    output logic        div_in_en,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_signed,
    output logic        writeback_en,
    output logic [4:0]  writeback_vregid,
    output logic [31:0] writeback_val,
    output logic        busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]  state;
    logic        last_grant;
    logic        drop;
    logic [1:0]  op_q;
    logic [4:0]  tag_q;

    logic        grant;
    logic        can_accept;
    logic        accept;
    logic [1:0]  sel_op;
    logic [4:0]  sel_tag;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic        b_zero;
    logic        special;
    logic [31:0] special_val;

    // op[2] carries no meaning for this block.
    logic        unused_op_bits;
    assign unused_op_bits = req0_op[2] ^ req1_op[2];

    // With both ports valid, the port that did not win last time gets the grant.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) grant = ~last_grant;
        else if (req1_valid)          grant = 1'b1;
    end

    assign can_accept = !rst && (state == IDLE) && !flush && div_idle;
    assign req0_ready = can_accept && req0_valid && !grant;
    assign req1_ready = can_accept && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;

    assign sel_op  = grant ? req1_op[1:0] : req0_op[1:0];
    assign sel_tag = grant ? req1_vregid  : req0_vregid;
    assign sel_a   = grant ? req1_a       : req0_a;
    assign sel_b   = grant ? req1_b       : req0_b;

    assign b_zero  = (sel_b == 32'd0);
    assign special = b_zero ||
                     (!sel_op[0] && sel_a == 32'h8000_0000 && sel_b == 32'hFFFF_FFFF);

    // Divide by zero: q = all ones, rem = a. Signed overflow: q = INT_MIN, rem = 0.
    always_comb begin
        special_val = 32'd0;
        if (sel_op[1]) special_val = b_zero ? sel_a : 32'd0;
        else           special_val = b_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
    end

    assign div_in_en  = !rst && (state == ISSUE) && !flush;
    assign div_signed = !op_q[0];
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            last_grant       <= 1'b1;
            drop             <= 1'b0;
            op_q             <= 2'd0;
            tag_q            <= 5'd0;
            div_a            <= 32'd0;
            div_b            <= 32'd0;
            writeback_en     <= 1'b0;
            writeback_vregid <= 5'd0;
            writeback_val    <= 32'd0;
        end else begin
            writeback_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_grant <= grant;
                        if (special) begin
                            writeback_en     <= 1'b1;
                            writeback_vregid <= sel_tag;
                            writeback_val    <= special_val;
                        end else begin
                            op_q  <= sel_op;
                            tag_q <= sel_tag;
                            div_a <= sel_a;
                            div_b <= sel_b;
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: state <= WAIT;  // flush here just abandons the op
                WAIT: begin
                    if (flush) drop <= 1'b1;
                    if (div_out_en) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                        if (!drop && !flush) begin
                            writeback_en     <= 1'b1;
                            writeback_vregid <= tag_q;
                            writeback_val    <= op_q[1] ? div_rem : div_q;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (state == ISSUE && flush) state <= IDLE;
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
module tb_div_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [2:0]  req0_op, req1_op;
    logic [4:0]  req0_vregid, req1_vregid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        flush, div_idle, div_out_en;
    logic [31:0] div_q, div_rem;
    logic        div_in_en, div_signed;
    logic [31:0] div_a, div_b;
    logic        writeback_en;
    logic [4:0]  writeback_vregid;
    logic [31:0] writeback_val;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    div_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_vregid(req0_vregid),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_vregid(req1_vregid),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .flush(flush), .div_idle(div_idle), .div_out_en(div_out_en),
        .div_q(div_q), .div_rem(div_rem),
        .div_in_en(div_in_en), .div_a(div_a), .div_b(div_b), .div_signed(div_signed),
        .writeback_en(writeback_en), .writeback_vregid(writeback_vregid),
        .writeback_val(writeback_val), .busy(busy)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0_valid = 1'b1; req0_op = 3'b001; req0_b = 32'd3; div_idle = 1'b1;
        tick();
        #1;
        n_cmp++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready0 got %b exp 0", req0_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", busy); end
        n_cmp++; if (writeback_en !== 1'b0 || div_in_en !== 1'b0) begin n_err++; $display("FAIL rst_pulses got wb=%b in=%b exp 0 0", writeback_en, div_in_en); end
        n_cmp++; if (writeback_val !== 32'd0 || div_a !== 32'd0 || writeback_vregid !== 5'd0) begin n_err++; $display("FAIL rst_data got %h %h %h exp 0", writeback_val, div_a, writeback_vregid); end
        req0_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unsigned_rem();
        req0_valid = 1'b1; req0_op = 3'b011; req0_a = 32'd100; req0_b = 32'd7; req0_vregid = 5'd5;
        #1;
        n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_err++; $display("FAIL urem_ready got %b%b exp 10", req0_ready, req1_ready); end
        tick();
        req0_valid = 1'b0;
        #1;
        n_cmp++; if (div_in_en !== 1'b1 || div_signed !== 1'b0) begin n_err++; $display("FAIL urem_issue got in=%b sg=%b exp 1 0", div_in_en, div_signed); end
        n_cmp++; if (div_a !== 32'd100 || div_b !== 32'd7 || busy !== 1'b1) begin n_err++; $display("FAIL urem_opnd got %0d %0d busy=%b exp 100 7 1", div_a, div_b, busy); end
        tick();
        n_cmp++; if (div_in_en !== 1'b0) begin n_err++; $display("FAIL urem_in_pulse got %b exp 0", div_in_en); end
        tick();
        div_out_en = 1'b1; div_q = 32'd14; div_rem = 32'd2;
        tick();
        div_out_en = 1'b0;
        n_cmp++; if (writeback_en !== 1'b1 || writeback_vregid !== 5'd5 || writeback_val !== 32'd2) begin n_err++; $display("FAIL urem_wb got en=%b tag=%0d val=%0d exp 1 5 2", writeback_en, writeback_vregid, writeback_val); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL urem_busy got %b exp 0", busy); end
        tick();
        n_cmp++; if (writeback_en !== 1'b0 || writeback_val !== 32'd2) begin n_err++; $display("FAIL urem_hold got en=%b val=%0d exp 0 2", writeback_en, writeback_val); end
    endtask

    task automatic test_div_zero();
        logic [2:0]  ops [2] = '{3'b000, 3'b010};
        logic [31:0] exp [2] = '{32'hFFFF_FFFF, 32'hFFFF_FFF7};
        for (int i = 0; i < 2; i++) begin
            req1_valid = 1'b1; req1_op = ops[i]; req1_a = -32'sd9; req1_b = 32'd0; req1_vregid = 5'd9;
            #1;
            n_cmp++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL dz_ready%0d got %b exp 1", i, req1_ready); end
            tick();
            req1_valid = 1'b0;
            #1;
            n_cmp++; if (writeback_en !== 1'b1 || writeback_val !== exp[i] || writeback_vregid !== 5'd9) begin n_err++; $display("FAIL dz_wb%0d got en=%b val=%h tag=%0d exp 1 %h 9", i, writeback_en, writeback_val, writeback_vregid, exp[i]); end
            n_cmp++; if (div_in_en !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL dz_bypass%0d got in=%b busy=%b exp 0 0", i, div_in_en, busy); end
            tick();
        end
    endtask

    task automatic test_overflow();
        logic [2:0]  ops [2] = '{3'b000, 3'b010};
        logic [31:0] exp [2] = '{32'h8000_0000, 32'h0};
        for (int i = 0; i < 2; i++) begin
            req0_valid = 1'b1; req0_op = ops[i]; req0_a = 32'h8000_0000; req0_b = 32'hFFFF_FFFF; req0_vregid = 5'd3;
            tick();
            req0_valid = 1'b0;
            n_cmp++; if (writeback_en !== 1'b1 || writeback_val !== exp[i] || busy !== 1'b0) begin n_err++; $display("FAIL ovf_wb%0d got en=%b val=%h busy=%b exp 1 %h 0", i, writeback_en, writeback_val, busy, exp[i]); end
            tick();
        end
        // The same operands unsigned are an ordinary division.
        req0_valid = 1'b1; req0_op = 3'b001;
        tick();
        req0_valid = 1'b0;
        n_cmp++; if (div_in_en !== 1'b1 || writeback_en !== 1'b0) begin n_err++; $display("FAIL ovf_unsigned got in=%b wb=%b exp 1 0", div_in_en, writeback_en); end
        tick();
        div_out_en = 1'b1; div_q = 32'd0; div_rem = 32'h8000_0000;
        tick();
        div_out_en = 1'b0;
        n_cmp++; if (writeback_en !== 1'b1 || writeback_val !== 32'd0) begin n_err++; $display("FAIL ovf_udiv_wb got en=%b val=%h exp 1 0", writeback_en, writeback_val); end
        tick();
    endtask

    task automatic test_fairness();
        // Reset returns the pointer so port 0 wins the first contest.
        rst = 1'b1; tick(); rst = 1'b0;
        req0_valid = 1'b1; req0_op = 3'b001; req0_a = 32'd50; req0_b = 32'd5; req0_vregid = 5'd1;
        req1_valid = 1'b1; req1_op = 3'b001; req1_a = 32'd60; req1_b = 32'd6; req1_vregid = 5'd2;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_cmp++; if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin n_err++; $display("FAIL fair_grant%0d got %b%b exp port %0d", i, req0_ready, req1_ready, i % 2); end
            tick();
            n_cmp++; if (div_in_en !== 1'b1 || div_a !== ((i % 2 == 0) ? 32'd50 : 32'd60)) begin n_err++; $display("FAIL fair_issue%0d got in=%b a=%0d", i, div_in_en, div_a); end
            tick();
            n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL fair_busy%0d got %b%b busy=%b exp 00 1", i, req0_ready, req1_ready, busy); end
            div_out_en = 1'b1; div_q = 32'd10 + i; div_rem = 32'd0;
            tick();
            div_out_en = 1'b0;
            n_cmp++; if (writeback_en !== 1'b1 || writeback_val !== 32'd10 + i || writeback_vregid !== ((i % 2 == 0) ? 5'd1 : 5'd2)) begin n_err++; $display("FAIL fair_wb%0d got en=%b val=%0d tag=%0d", i, writeback_en, writeback_val, writeback_vregid); end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        // Flush in IDLE blocks a special op entirely.
        req0_valid = 1'b1; req0_op = 3'b000; req0_b = 32'd0; flush = 1'b1;
        #1;
        n_cmp++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL flush_idle_ready got %b exp 0", req0_ready); end
        tick();
        flush = 1'b0; req0_valid = 1'b0;
        n_cmp++; if (writeback_en !== 1'b0) begin n_err++; $display("FAIL flush_idle_wb got %b exp 0", writeback_en); end
        // div_idle low blocks acceptance.
        req0_valid = 1'b1; div_idle = 1'b0;
        #1;
        n_cmp++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL div_busy_ready got %b exp 0", req0_ready); end
        req0_valid = 1'b0; div_idle = 1'b1;
        // A stray divider result in IDLE is ignored.
        div_out_en = 1'b1;
        tick();
        div_out_en = 1'b0;
        n_cmp++; if (writeback_en !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL stray_out got wb=%b busy=%b exp 0 0", writeback_en, busy); end
        // Flush in ISSUE suppresses the start pulse.
        req0_valid = 1'b1; req0_op = 3'b001; req0_a = 32'd9; req0_b = 32'd3;
        tick();
        req0_valid = 1'b0; flush = 1'b1;
        #1;
        n_cmp++; if (div_in_en !== 1'b0) begin n_err++; $display("FAIL flush_issue_in got %b exp 0", div_in_en); end
        tick();
        flush = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_issue_busy got %b exp 0", busy); end
        // Flush in WAIT two cycles after the start pulse drops the result.
        req0_valid = 1'b1; req0_vregid = 5'd7;
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush_wait_hold got busy=%b exp 1", busy); end
        div_out_en = 1'b1; div_q = 32'd3;
        tick();
        div_out_en = 1'b0;
        n_cmp++; if (writeback_en !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL flush_wait_drop got wb=%b busy=%b exp 0 0", writeback_en, busy); end
        req1_valid = 1'b1; req1_op = 3'b001; req1_a = 32'd8; req1_b = 32'd2; req1_vregid = 5'd4;
        #1;
        n_cmp++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL flush_wait_next got %b exp 1", req1_ready); end
        tick();
        req1_valid = 1'b0;
        tick();
        div_out_en = 1'b1; div_q = 32'd4;
        tick();
        div_out_en = 1'b0;
        n_cmp++; if (writeback_en !== 1'b1 || writeback_val !== 32'd4 || writeback_vregid !== 5'd4) begin n_err++; $display("FAIL flush_drop_clear got en=%b val=%0d tag=%0d exp 1 4 4", writeback_en, writeback_val, writeback_vregid); end
        tick();
    endtask

    task automatic test_reset_mid();
        req0_valid = 1'b1; req0_op = 3'b001; req0_a = 32'd21; req0_b = 32'd4;
        tick();
        req0_valid = 1'b0;
        tick();
        rst = 1'b1; div_out_en = 1'b1; div_q = 32'd5;
        tick();
        rst = 1'b0; div_out_en = 1'b0;
        n_cmp++; if (busy !== 1'b0 || div_in_en !== 1'b0 || writeback_en !== 1'b0) begin n_err++; $display("FAIL rst_mid got busy=%b in=%b wb=%b exp 0 0 0", busy, div_in_en, writeback_en); end
        tick();
        n_cmp++; if (writeback_en !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_after got wb=%b busy=%b exp 0 0", writeback_en, busy); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; div_idle = 1'b1; div_out_en = 1'b0;
        div_q = '0; div_rem = '0;
        req0_valid = 1'b0; req0_op = '0; req0_vregid = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = '0; req1_vregid = '0; req1_a = '0; req1_b = '0;
        test_reset();
        test_unsigned_rem();
        test_div_zero();
        test_overflow();
        test_fairness();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout compared=%0d", n_cmp);
        $fatal(1);
    end
endmodule
